// File: rtl/ula_pkg.sv
// Shared opcode map, FSM states and flag bundle for the sequential ULA.
package ula_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 5'b00000,
        OP_ADDC   = 5'b00001,
        OP_INC    = 5'b00011,
        OP_SUBB   = 5'b00100,
        OP_SUB    = 5'b00101,
        OP_DEC    = 5'b00110,
        OP_LSL    = 5'b01000,
        OP_ASR    = 5'b01001,
        OP_LSR    = 5'b01010,
        OP_MUL    = 5'b01100,
        OP_ZERO   = 5'b10000,
        OP_AND    = 5'b10001,
        OP_NA_B   = 5'b10010,
        OP_B      = 5'b10011,
        OP_A_NB   = 5'b10100,
        OP_A      = 5'b10101,
        OP_XOR    = 5'b10110,
        OP_OR     = 5'b10111,
        OP_NOR    = 5'b11000,
        OP_XNOR   = 5'b11001,
        OP_NA     = 5'b11010,
        OP_NA_OR  = 5'b11011,
        OP_NB     = 5'b11100,
        OP_A_ORNB = 5'b11101,
        OP_NAND   = 5'b11110,
        OP_ONE    = 5'b11111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MULT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
        logic o;
    } flags_t;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_LSL) || (op == OP_ASR) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/ula_comb.sv
// Single-cycle ULA datapath: arithmetic, logic and unlisted opcodes with Z/C/S/O.
// Shift opcodes return A unshifted (the shamt=0 result); the top does the actual shifting.
module ula_comb
    import ula_pkg::*;
#(
    parameter int unsigned BITS_PALAVRA = 16
) (
    input  logic [OP_W-1:0]         op_i,
    input  logic [BITS_PALAVRA-1:0] a_i,
    input  logic [BITS_PALAVRA-1:0] b_i,
    output logic [BITS_PALAVRA-1:0] res_c_o,
    output flags_t                  flags_c_o
);

    localparam int unsigned W = BITS_PALAVRA;

    logic [W-1:0] op2;
    logic         cin;
    logic         arith;
    logic [W:0]   sum;
    logic [W-1:0] logic_res;
    logic [W-1:0] res;
    logic         c_flag;
    logic         o_flag;

    // Effective second operand and carry-in for the adder-based opcodes
    always_comb begin
        op2   = '0;
        cin   = 1'b0;
        arith = 1'b0;
        case (op_i)
            OP_ADD:  begin op2 = b_i;  arith = 1'b1;             end
            OP_ADDC: begin op2 = b_i;  arith = 1'b1; cin = 1'b1; end
            OP_INC:  begin op2 = '0;   arith = 1'b1; cin = 1'b1; end
            OP_SUBB: begin op2 = ~b_i; arith = 1'b1;             end
            OP_SUB:  begin op2 = ~b_i; arith = 1'b1; cin = 1'b1; end
            OP_DEC:  begin op2 = '1;   arith = 1'b1;             end
            default: ;
        endcase
    end

    assign sum = {1'b0, a_i} + {1'b0, op2} + (W+1)'(cin);

    always_comb begin
        logic_res = '0;
        case (op_i[3:0])
            4'h0: logic_res = '0;
            4'h1: logic_res = a_i & b_i;
            4'h2: logic_res = ~a_i & b_i;
            4'h3: logic_res = b_i;
            4'h4: logic_res = a_i & ~b_i;
            4'h5: logic_res = a_i;
            4'h6: logic_res = a_i ^ b_i;
            4'h7: logic_res = a_i | b_i;
            4'h8: logic_res = ~a_i & ~b_i;
            4'h9: logic_res = ~(a_i ^ b_i);
            4'hA: logic_res = ~a_i;
            4'hB: logic_res = ~a_i | b_i;
            4'hC: logic_res = ~b_i;
            4'hD: logic_res = a_i | ~b_i;
            4'hE: logic_res = ~a_i | ~b_i;
            4'hF: logic_res = '1;
        endcase
    end

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        o_flag = 1'b0;
        if (arith) begin
            res    = sum[W-1:0];
            c_flag = sum[W];
            o_flag = (a_i[W-1] == op2[W-1]) && (sum[W-1] != a_i[W-1]);
        end else if (op_i[4]) begin
            res = logic_res;
        end else if (is_shift(op_i)) begin
            res = a_i;
        end
        res_c_o     = res;
        flags_c_o.z = (res == '0);
        flags_c_o.c = c_flag;
        flags_c_o.s = res[W-1];
        flags_c_o.o = o_flag;
    end

endmodule

// File: rtl/ula_sequencial.sv
// Registered ULA with valid/ready handshakes and 1-bit-per-clock shifts.
// Define ULA_MULT_EN to add the signed shift-add multiplier on opcode 01100.
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int unsigned BITS_PALAVRA = 16,
    parameter int unsigned BITS_SHAMT   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         controle,
    input  logic [BITS_PALAVRA-1:0] operandoA,
    input  logic [BITS_PALAVRA-1:0] operandoB,
    input  logic [BITS_SHAMT-1:0]   shamt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BITS_PALAVRA-1:0] resultadoOp,
    output logic                    Z,
    output logic                    C,
    output logic                    S,
    output logic                    O
);

    localparam int unsigned W       = BITS_PALAVRA;
    localparam int unsigned MCNT_W  = $clog2(W + 1);
    localparam int unsigned CNT_W   = (BITS_SHAMT > MCNT_W) ? BITS_SHAMT : MCNT_W;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [W-1:0]      sh_q, sh_d;
    logic              sh_c_q, sh_c_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      res_q, res_d;
    flags_t            flg_q, flg_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;
    logic [W-1:0]      comb_res;
    flags_t            comb_flags;

`ifdef ULA_MULT_EN
    logic [2*W-1:0]    acc_q, acc_d;
    logic [2*W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]      mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [2*W-1:0]    prod;
    logic [W-1:0]      mag_a, mag_b;

    assign mag_a = operandoA[W-1] ? W'(-operandoA) : operandoA;
    assign mag_b = operandoB[W-1] ? W'(-operandoB) : operandoB;
`endif

    assign accept = in_valid && (state_q == IDLE);

    ula_comb #(.BITS_PALAVRA(W)) u_comb (
        .op_i      (controle),
        .a_i       (operandoA),
        .b_i       (operandoB),
        .res_c_o   (comb_res),
        .flags_c_o (comb_flags)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sh_q        <= '0;
            sh_c_q      <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            flg_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ULA_MULT_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            sh_c_q      <= sh_c_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            flg_q       <= flg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ULA_MULT_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
`endif
        end
    end

    // Next state: SHIFT/MULT run until the counter's last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift(controle) && (shamt != '0))
                        state_d = SHIFT;
`ifdef ULA_MULT_EN
                    else if (controle == OP_MUL)
                        state_d = MULT;
`endif
                    else
                        state_d = DONE;
                end
            end
            SHIFT, MULT: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:        if (out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Datapath and handshake outputs
    always_comb begin
        op_d        = op_q;
        sh_d        = sh_q;
        sh_c_d      = sh_c_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        flg_d       = flg_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
`ifdef ULA_MULT_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        prod        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = controle;
                    sh_d   = operandoA;
                    sh_c_d = 1'b0;
                    cnt_d  = CNT_W'(shamt);
                    res_d  = comb_res;
                    flg_d  = comb_flags;
`ifdef ULA_MULT_EN
                    if (controle == OP_MUL) begin
                        cnt_d    = CNT_W'(W);
                        acc_d    = '0;
                        mcand_d  = {W'(0), mag_a};
                        mplier_d = mag_b;
                        neg_d    = operandoA[W-1] ^ operandoB[W-1];
                    end
`endif
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_LSL: begin
                        sh_d   = {sh_q[W-2:0], 1'b0};
                        sh_c_d = sh_q[W-1];
                    end
                    OP_ASR: begin
                        sh_d   = {sh_q[W-1], sh_q[W-1:1]};
                        sh_c_d = sh_q[0];
                    end
                    default: begin
                        sh_d   = {1'b0, sh_q[W-1:1]};
                        sh_c_d = sh_q[0];
                    end
                endcase
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = sh_d;
                    flg_d.z = (sh_d == '0);
                    flg_d.c = sh_c_d;
                    flg_d.s = sh_d[W-1];
                    flg_d.o = 1'b0;
                end
            end
`ifdef ULA_MULT_EN
            // Unsigned magnitude product, sign applied on the final step
            MULT: begin
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod    = neg_q ? (~acc_d + (2*W)'(1)) : acc_d;
                    res_d   = prod[W-1:0];
                    flg_d.z = (prod[W-1:0] == '0);
                    flg_d.c = 1'b0;
                    flg_d.s = prod[W-1];
                    flg_d.o = ~((&prod[2*W-1:W-1]) | ~(|prod[2*W-1:W-1]));
                end
            end
`endif
            default: ;
        endcase
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign resultadoOp = res_q;
    assign Z           = flg_q.z;
    assign C           = flg_q.c;
    assign S           = flg_q.s;
    assign O           = flg_q.o;

endmodule
